// File: rtl/key_input_conditioner_pkg.sv
// Shared definitions for the button front end.
//   DEFAULT_FRQ : default clk frequency in Hz, same value mainController/piezoController use
//   KEY_W       : number of game buttons
//   state_e     : conditioner FSM states
//   is_one_hot  : true when exactly one bit of a key vector is set
package key_input_conditioner_pkg;

  localparam int unsigned DEFAULT_FRQ = 1_000_000;
  localparam int unsigned KEY_W       = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_input_conditioner_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input lines
//   q     : synchronised lines, two clk edges behind d
module key_input_conditioner_sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Button front end: synchronises and debounces 8 raw buttons and presents a
// single pressed key one-hot, held for as long as that key stays pressed.
//   clk         : system clock
//   nrst        : asynchronous active-low reset
//   key_raw     : raw active-high buttons, asynchronous, may bounce
//   key         : debounced one-hot key, 0 = none; held while pressed
//   key_pulse   : one-cycle strobe on the cycle key becomes non-zero
//   multi_press : one-cycle strobe when a debounced press was a chord (rejected)
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int unsigned FRQ         = DEFAULT_FRQ,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] key,
  output logic             key_pulse,
  output logic             multi_press
);

  localparam int unsigned DB_CYCLES = FRQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned CNT_W     = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [KEY_W-1:0] ks;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_pulse_q, key_pulse_d;
  logic             multi_press_q, multi_press_d;

  key_input_conditioner_sync2 #(
    .WIDTH(KEY_W)
  ) u_sync (
    .clk  (clk),
    .rst_n(nrst),
    .d    (key_raw),
    .q    (ks)
  );

  // The whole debounced pattern must stay identical through the press window,
  // so a chord that changes shape mid-press restarts from IDLE. Chords that are
  // stable still park in HELD so they cannot turn into a key until fully released.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cand_d        = cand_q;
    key_d         = key_q;
    key_pulse_d   = 1'b0;
    multi_press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ks != '0) begin
          cand_d  = ks;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (ks != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = HELD;
          if (is_one_hot(cand_q)) begin
            key_d       = cand_q;
            key_pulse_d = 1'b1;
          end else begin
            multi_press_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (ks == '0) begin
          cnt_d   = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (ks != '0) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          key_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        key_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_q         <= '0;
      key_pulse_q   <= 1'b0;
      multi_press_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_q         <= key_d;
      key_pulse_q   <= key_pulse_d;
      multi_press_q <= multi_press_d;
    end
  end

  assign key         = key_q;
  assign key_pulse   = key_pulse_q;
  assign multi_press = multi_press_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DB_CYCLES=4.
module tb_key_input_conditioner;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] key_raw;
  logic [7:0] key;
  logic       key_pulse;
  logic       multi_press;

  int unsigned errors = 0;
  int unsigned checks = 0;

  key_input_conditioner #(
    .FRQ        (1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .key_raw    (key_raw),
    .key        (key),
    .key_pulse  (key_pulse),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  // One segment: hold raw for 'cycles' edges, expecting the given outputs after each edge.
  typedef struct {
    logic [7:0]  raw;
    int unsigned cycles;
    logic [7:0]  exp_key;
    logic        exp_pulse;
    logic        exp_multi;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] raw, input int unsigned n, input logic [7:0] k,
                     input logic p, input logic m, input string name);
    vec_t v;
    v.raw = raw; v.cycles = n; v.exp_key = k; v.exp_pulse = p; v.exp_multi = m; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] ek, input logic ep,
                           input logic em);
    check({name, ".key"}, key, ek);
    check({name, ".pulse"}, {7'd0, key_pulse}, {7'd0, ep});
    check({name, ".multi"}, {7'd0, multi_press}, {7'd0, em});
  endtask

  // Hold raw for n edges, checking after each edge.
  task automatic hold(input logic [7:0] raw, input int unsigned n, input logic [7:0] ek,
                      input logic ep, input logic em, input string name);
    for (int unsigned i = 0; i < n; i++) begin
      key_raw = raw;
      tick();
      check_out(name, ek, ep, em);
    end
  endtask

  initial begin
    // Clean press of 8'h10: 20 cycles held, key visible on the 7th edge.
    add(8'h10,  6, 8'h00, 1'b0, 1'b0, "t1_press_wait");
    add(8'h10,  1, 8'h10, 1'b1, 1'b0, "t1_press_edge");
    add(8'h10, 13, 8'h10, 1'b0, 1'b0, "t1_held");
    add(8'h00,  6, 8'h10, 1'b0, 1'b0, "t1_rel_wait");
    add(8'h00,  1, 8'h00, 1'b0, 1'b0, "t1_rel_edge");
    add(8'h00,  3, 8'h00, 1'b0, 1'b0, "t1_idle");
    // Chord 8'h03: multi_press strobe only, then a real press of 8'h01.
    add(8'h03,  6, 8'h00, 1'b0, 1'b0, "t3_chord_wait");
    add(8'h03,  1, 8'h00, 1'b0, 1'b1, "t3_chord_edge");
    add(8'h03, 13, 8'h00, 1'b0, 1'b0, "t3_chord_held");
    add(8'h00,  8, 8'h00, 1'b0, 1'b0, "t3_chord_rel");
    add(8'h01,  6, 8'h00, 1'b0, 1'b0, "t3_single_wait");
    add(8'h01,  1, 8'h01, 1'b1, 1'b0, "t3_single_edge");
    add(8'h01,  3, 8'h01, 1'b0, 1'b0, "t4_held");
    // Extra key on top of a held key is ignored.
    add(8'h81,  5, 8'h01, 1'b0, 1'b0, "t4_extra_key");
    add(8'h00,  6, 8'h01, 1'b0, 1'b0, "t4_rel_wait");
    add(8'h00,  1, 8'h00, 1'b0, 1'b0, "t4_rel_edge");
    add(8'h00,  2, 8'h00, 1'b0, 1'b0, "t4_idle");

    nrst    = 1'b0;
    key_raw = 8'h00;
    #12;
    check_out("reset_state", 8'h00, 1'b0, 1'b0);
    tick();
    nrst = 1'b1;
    hold(8'h00, 3, 8'h00, 1'b0, 1'b0, "idle_after_reset");

    foreach (vecs[i]) begin
      hold(vecs[i].raw, vecs[i].cycles, vecs[i].exp_key, vecs[i].exp_pulse,
           vecs[i].exp_multi, vecs[i].name);
    end

    // Press bounce: 2-cycle bursts never survive the press window.
    for (int unsigned b = 0; b < 5; b++) begin
      hold(8'h04, 2, 8'h00, 1'b0, 1'b0, "t2_bounce_hi");
      hold(8'h00, 2, 8'h00, 1'b0, 1'b0, "t2_bounce_lo");
    end
    hold(8'h04, 6, 8'h00, 1'b0, 1'b0, "t2_settle_wait");
    hold(8'h04, 1, 8'h04, 1'b1, 1'b0, "t2_settle_edge");
    hold(8'h00, 6, 8'h04, 1'b0, 1'b0, "t2_rel_wait");
    hold(8'h00, 3, 8'h00, 1'b0, 1'b0, "t2_idle");

    // Release bounce: 2-cycle drop while held keeps the key, no new strobe.
    hold(8'h20, 6, 8'h00, 1'b0, 1'b0, "t5_press_wait");
    hold(8'h20, 1, 8'h20, 1'b1, 1'b0, "t5_press_edge");
    hold(8'h20, 3, 8'h20, 1'b0, 1'b0, "t5_held");
    hold(8'h00, 2, 8'h20, 1'b0, 1'b0, "t5_drop");
    hold(8'h20, 10, 8'h20, 1'b0, 1'b0, "t5_back");
    hold(8'h00, 6, 8'h20, 1'b0, 1'b0, "t5_rel_wait");
    hold(8'h00, 3, 8'h00, 1'b0, 1'b0, "t5_idle");

    // Async reset in the middle of the press window.
    hold(8'h08, 3, 8'h00, 1'b0, 1'b0, "t6_pressdb");
    #3 nrst = 1'b0;
    #1 check_out("t6_rst_pressdb", 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    nrst = 1'b1;
    hold(8'h08, 6, 8'h00, 1'b0, 1'b0, "t6_redb1_wait");
    hold(8'h08, 1, 8'h08, 1'b1, 1'b0, "t6_redb1_edge");
    // Async reset while held, right on the strobe cycle.
    #3 nrst = 1'b0;
    #1 check_out("t6_rst_held", 8'h00, 1'b0, 1'b0);
    tick();
    check_out("t6_in_reset", 8'h00, 1'b0, 1'b0);
    tick();
    nrst = 1'b1;
    hold(8'h08, 6, 8'h00, 1'b0, 1'b0, "t6_redb2_wait");
    hold(8'h08, 1, 8'h08, 1'b1, 1'b0, "t6_redb2_edge");
    hold(8'h08, 2, 8'h08, 1'b0, 1'b0, "t6_held");
    hold(8'h00, 6, 8'h08, 1'b0, 1'b0, "t6_rel_wait");
    hold(8'h00, 2, 8'h00, 1'b0, 1'b0, "t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
